alu_shift_add_multiplier: RTL

Sequencer that performs an unsigned 8×8→16-bit multiply by time-sharing the existing 8-bit adder/subtractor. It drives the adder's operand and carry-in inputs through a shift-and-add state machine over 16 cycles, and returns a registered 16-bit product. It sits beside the comparator in the ALU top level. When `AddSel` is high, the top level muxes the adder inputs from this block instead of from the switch operands.

---
 rtl/alu_shift_add_multiplier.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_shift_add_multiplier.sv
// rtl/alu_shift_add_multiplier.sv - unsigned 8x8 shift-and-add multiplier sequencing the shared ALU adder
// The adder is external: this block drives AddX/AddY/AddCin and samples AddSum/AddCout in ADD.

module alu_shift_add_multiplier (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   input  logic [7:0]  AddSum,
   input  logic        AddCout,
   output logic [7:0]  AddX,
   output logic [7:0]  AddY,
   output logic        AddCin,
   output logic        AddSel,
   output logic        Busy,
   output logic        Done,
   output logic [15:0] Product
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  m_q, m_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  lo_q, lo_d;
   logic        c_q, c_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] product_q, product_d;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= S_IDLE;
         m_q       <= 8'h00;
         hi_q      <= 8'h00;
         lo_q      <= 8'h00;
         c_q       <= 1'b0;
         cnt_q     <= 3'd0;
         product_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         c_q       <= c_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (Start) state_d = S_ADD;
         S_ADD:   state_d = S_SHIFT;
         S_SHIFT: state_d = (cnt_q == 3'd7) ? S_DONE : S_ADD;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      m_d       = m_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               m_d   = A;
               lo_d  = B;
               hi_d  = 8'h00;
               c_d   = 1'b0;
               cnt_d = 3'd0;
            end
         end
         S_ADD: begin
            if (lo_q[0]) begin
               hi_d = AddSum;
               c_d  = AddCout;
            end else begin
               c_d  = 1'b0;
            end
         end
         S_SHIFT: begin
            // Carry re-enters at the top so 0xFF x 0xFF stays exact.
            hi_d  = {c_q, hi_q[7:1]};
            lo_d  = {hi_q[0], lo_q[7:1]};
            c_d   = 1'b0;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               product_d = {c_q, hi_q, lo_q[7:1]};
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      Busy    = (state_q == S_ADD) || (state_q == S_SHIFT);
      AddSel  = Busy;
      Done    = (state_q == S_DONE);
      AddX    = hi_q;
      AddY    = m_q;
      AddCin  = 1'b0;
      Product = product_q;
   end

endmodule
